// File: rtl/tdc_delay_scheduler.sv
// Round-robin sharing of one TDC-to-delay converter across N_CH channels.
// Optional macro TDS_TIMEOUT_EN adds a conv_done watchdog that reports out_err.
module tdc_delay_scheduler #(
  parameter int N_CH    = 4,
  parameter int CH_W    = $clog2(N_CH),
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [22*N_CH-1:0] ch_timedata,
  input  logic [N_CH-1:0]    ch_data_flag,
  output logic               conv_start,
  output logic [21:0]        conv_timedata,
  input  logic               conv_done,
  input  logic [14:0]        conv_delaydata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [14:0]        out_delay,
  output logic [CH_W-1:0]    out_ch,
  output logic               out_err,
  output logic [N_CH-1:0]    overrun,
  output logic [15:0]        drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N_CH-1:0] r_pend;
  logic [21:0]     r_ts [N_CH];
  logic [CH_W-1:0] r_rr;
  logic [CH_W-1:0] r_grant;
  logic [21:0]     r_conv_td;
  logic [14:0]     r_dly;
  logic [CH_W-1:0] r_och;
  logic [N_CH-1:0] r_ovr;
  logic [15:0]     r_drop_cnt;

  logic [N_CH-1:0] w_clr;
  logic [N_CH-1:0] w_cap;
  logic [N_CH-1:0] w_drop;
  logic [CH_W-1:0] w_sel;
  logic            w_any;
  logic [16:0]     w_ndrop;
  logic [16:0]     w_dsum;
  logic            w_timeout;

  function automatic logic [CH_W-1:0] wrap(input int v);
    return CH_W'(v % N_CH);
  endfunction

  // Walk downward so the smallest offset from the pointer wins.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (r_pend[wrap(int'(r_rr) + k)]) begin
        w_any = 1'b1;
        w_sel = wrap(int'(r_rr) + k);
      end
    end
  end

  // A flag landing on the ISSUE cycle refills the slot being freed.
  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_clr[i]  = (r_state == S_ISSUE) &&
                  (r_grant == CH_W'(i));
      w_cap[i]  = ch_data_flag[i] &&
                  (!r_pend[i] || w_clr[i]);
      w_drop[i] = ch_data_flag[i] &&
                  r_pend[i] && !w_clr[i];
      w_ndrop   = w_ndrop + 17'(w_drop[i]);
    end
    w_dsum = {1'b0, r_drop_cnt} + w_ndrop;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (conv_done || w_timeout)
                 w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_pend     <= '0;
      r_rr       <= '0;
      r_grant    <= '0;
      r_conv_td  <= '0;
      r_dly      <= '0;
      r_och      <= '0;
      r_ovr      <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < N_CH; i++)
        r_ts[i] <= '0;
    end else begin
      r_state <= w_next;
      for (int i = 0; i < N_CH; i++) begin
        r_pend[i] <= w_cap[i] |
                     (r_pend[i] & ~w_clr[i]);
        if (w_cap[i])
          r_ts[i] <= ch_timedata[22*i +: 22];
        if (w_drop[i])
          r_ovr[i] <= 1'b1;
      end
      r_drop_cnt <= w_dsum[16] ? 16'hFFFF
                               : w_dsum[15:0];
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant   <= w_sel;
            r_conv_td <= r_ts[w_sel];
          end
        end
        S_ISSUE: begin
          r_rr <= (r_grant == CH_W'(N_CH - 1))
                  ? '0 : r_grant + 1'b1;
        end
        S_WAIT: begin
          if (conv_done) begin
            r_dly <= conv_delaydata;
            r_och <= r_grant;
          end else if (w_timeout) begin
            r_dly <= '0;
            r_och <= r_grant;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TDS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_timeout = (r_state == S_WAIT) &&
                     !conv_done &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)
        r_cnt <= '0;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_WAIT) begin
        if (conv_done)
          r_err <= 1'b0;
        else if (w_timeout)
          r_err <= 1'b1;
      end
    end
  end

  assign out_err = r_err;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (TIMEOUT > 0);
  assign w_timeout    = 1'b0;
  assign out_err      = 1'b0;
`endif

  assign conv_start    = (r_state == S_ISSUE);
  assign out_valid     = (r_state == S_OUT);
  assign conv_timedata = r_conv_td;
  assign out_delay     = r_dly;
  assign out_ch        = r_och;
  assign overrun       = r_ovr;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: doc/tdc_delay_scheduler.md
Name: tdc_delay_scheduler

Overview:
- Shares one TDC-to-delay conversion unit between N_CH TDC channels.
- Captures each channel's 22-bit timestamp on its data_flag pulse and holds it as a pending request.
- Grants pending requests round-robin, issues one conversion at a time to the shared converter, and returns each 15-bit delay result tagged with its channel on a valid/ready output.
- Sits between the per-channel TDC front ends and the delay-line programming logic.

Parameters:
- N_CH, 4, number of TDC channels (2..16)
- CH_W, $clog2(N_CH), channel id width (derived; do not override)
- TIMEOUT, 64, cycles allowed for conv_done (used only with TDS_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- ch_timedata  in  22*N_CH  per-channel timestamps; channel i at bits [22*i+21:22*i]
- ch_data_flag  in  N_CH  per-channel one-cycle capture strobes, synchronous to clk
- conv_start  out  1  one-cycle pulse starting a conversion
- conv_timedata  out  22  timestamp presented to the converter; stable from conv_start until conv_done
- conv_done  in  1  one-cycle pulse, converter result valid
- conv_delaydata  in  15  converter result, sampled when conv_done=1
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_delay  out  15  delay result
- out_ch  out  CH_W  channel the result belongs to
- out_err  out  1  result invalid because of a timeout (constant 0 without TDS_TIMEOUT_EN)
- overrun  out  N_CH  sticky per-channel flag: a capture was dropped
- drop_cnt  out  16  saturating count of dropped captures, all channels

Behaviour:
- Reset (resetn=0 at a posedge clk) clears:
  - FSM to IDLE, all pending bits, the RR pointer (to 0), all captured timestamps
  - outputs conv_start, conv_timedata, out_valid, out_delay, out_ch, out_err, overrun, drop_cnt all 0
- Reset mid-operation abandons any conversion in flight. A conv_done arriving after reset, while in IDLE, is ignored.
- Capture, evaluated per channel i every cycle:
  - flag=1 and pending[i]=0: latch ch_timedata[i] and set pending[i].
  - flag=1 and pending[i]=1 and pending[i] is not being cleared this cycle: drop the new sample (keep the oldest), set overrun[i], increment drop_cnt (saturate at 0xFFFF).
  - flag=1 in the same cycle pending[i] is cleared (ISSUE state): capture the new sample and keep pending[i] set. This is not an overrun.
- FSM states: IDLE, ISSUE, WAIT, OUT.
  - IDLE: if any pending bit is set, grant the first set bit searching upward from the RR pointer, wrapping modulo N_CH. Register the grant, load conv_timedata from that channel's captured timestamp, and go to ISSUE. If no bit is set, stay in IDLE.
  - ISSUE: conv_start=1 for exactly this cycle; clear pending[grant]; RR pointer <= grant+1 mod N_CH. Go to WAIT.
  - WAIT: on conv_done, out_delay <= conv_delaydata, out_ch <= grant, out_err <= 0. Go to OUT.
  - OUT: out_valid=1, with out_delay, out_ch and out_err held stable until out_valid&&out_ready. On that handshake, out_valid falls the next cycle and the FSM goes to IDLE.
- Latency: from a flag in cycle t on an idle block, conv_start is asserted in cycle t+2. out_valid is asserted 1 cycle after conv_done.
- Throughput: at most one conversion outstanding. Minimum spacing between conv_start pulses is 4 cycles, assuming conv_done returns 1 cycle after conv_start and out_ready is held at 1.
- conv_done outside WAIT is ignored.
- Single channel continuously pending: that channel is served back-to-back. Fairness applies only among channels that are pending.

Optional Feature:
- Macro: TDS_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT cycles elapse without conv_done: out_delay <= 0, out_ch <= grant, out_err <= 1, and the FSM goes to OUT.
  - The sample is consumed and is not retried.
  - A late conv_done arriving afterwards is ignored.
- Not defined:
  - WAIT is held indefinitely until conv_done.
  - out_err is tied to 0 and there is no counter logic.

Test Plan:
- Single capture:
  - Stimulus: flag ch2 with timedata=5000; converter returns 19 one cycle after start; out_ready=1.
  - Required: conv_start 2 cycles after the flag with conv_timedata=5000; then out_valid with out_delay=19, out_ch=2, out_err=0.
- Round robin:
  - Stimulus: flags on ch0..ch3 in the same cycle with distinct values.
  - Required: results in channel order 0,1,2,3. A second simultaneous burst is served starting from ch0 again, because the pointer has wrapped.
- Overrun:
  - Stimulus: ch1 flagged with value A, held in OUT by out_ready=0; ch1 flagged with A then B while pending.
  - Required: B dropped; overrun[1]=1; drop_cnt=1; the next ch1 conversion uses the value captured before B.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles.
  - Required: out_valid stays 1; out_delay and out_ch stable; no new conv_start until the handshake.
- Same-cycle clear and capture:
  - Stimulus: flag ch0 exactly in its ISSUE cycle.
  - Required: second capture kept, no overrun, ch0 converted again.
- Reset in WAIT, and timeout with TDS_TIMEOUT_EN:
  - Reset in WAIT: resetn=0 for 1 cycle mid-conversion → all outputs 0; a later stray conv_done produces no output.
  - Timeout (with TDS_TIMEOUT_EN): no conv_done for 64 cycles → out_valid with out_err=1, out_delay=0.
